// File: rtl/divisao_sequencial.sv
// rtl/divisao_sequencial.sv - sequential restoring divider, one quotient bit per clock
// Start/Finalizado handshake; a zero divisor short-circuits straight to FIM with an error flag.
module divisao_sequencial #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [N-1:0] Dividendo,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quociente,
  output logic [N-1:0] Resto,
  output logic         Finalizado,
  output logic         Ocupado,
  output logic         ErroDivZero
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  d_q;
  logic [N-1:0]  q_q;
  logic [N:0]    r_q;
  logic [N-1:0]  quoc_q;
  logic [N-1:0]  resto_q;
  logic          err_q;
  logic          fin_q;
  logic          ocup_q;

  logic [N:0]    r_sh;
  logic [N+1:0]  t;
  logic          ge;
  logic [N:0]    r_d;
  logic [N-1:0]  q_d;

  // One restoring step: shift {R,Q} left, trial-subtract D in N+2 bits so the sign bit is free.
  always_comb begin
    r_sh = {r_q[N-1:0], q_q[N-1]};
    t    = {1'b0, r_sh} - {2'b00, d_q};
    ge   = ~t[N+1];
    r_d  = ge ? t[N:0] : r_sh;
    q_d  = {q_q[N-2:0], ge};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quoc_q  <= '0;
      resto_q <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (Start) begin
            if (Divisor != '0) begin
              d_q     <= Divisor;
              q_q     <= Dividendo;
              r_q     <= '0;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              ocup_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              quoc_q  <= '1;
              resto_q <= Dividendo;
              err_q   <= 1'b1;
              fin_q   <= 1'b1;
              state_q <= FIM;
            end
          end
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            quoc_q  <= q_d;
            resto_q <= r_d[N-1:0];
            ocup_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= FIM;
          end
        end
        FIM: begin
          fin_q   <= 1'b0;
          state_q <= OCIOSO;
        end
        default: begin
          fin_q   <= 1'b0;
          ocup_q  <= 1'b0;
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign Quociente   = quoc_q;
  assign Resto       = resto_q;
  assign Finalizado  = fin_q;
  assign Ocupado     = ocup_q;
  assign ErroDivZero = err_q;

endmodule

// File: tb/tb_divisao_sequencial.sv
// tb/tb_divisao_sequencial.sv - scoreboard bench for divisao_sequencial
// Expected results come from plain integer division; a monitor pops them on each Finalizado.
module tb_divisao_sequencial;
  localparam int N  = 8;
  localparam int CW = 3;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [N-1:0] Dividendo;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quociente;
  logic [N-1:0] Resto;
  logic         Finalizado;
  logic         Ocupado;
  logic         ErroDivZero;

  divisao_sequencial #(.N(N), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .Dividendo(Dividendo), .Divisor(Divisor),
    .Quociente(Quociente), .Resto(Resto),
    .Finalizado(Finalizado), .Ocupado(Ocupado), .ErroDivZero(ErroDivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = N'(a);
      e.e = 1'b1;
    end else begin
      e.q = N'(a / b);
      e.r = N'(a % b);
      e.e = 1'b0;
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    if (!Rst && Finalizado) begin
      if (sb.size() == 0) begin
        chk("unexpected_finalizado", 32'(Finalizado), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quociente", 32'(Quociente), 32'(mon_e.q));
        chk("resto", 32'(Resto), 32'(mon_e.r));
        chk("erro_div_zero", 32'(ErroDivZero), 32'(mon_e.e));
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while ((Ocupado || Finalizado) && w < 40) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 40) chk("idle_timeout", 32'(w), 32'd0);
  endtask

  task automatic run_op(input int a, input int b);
    logic [2*N-1:0] pre;
    int k;
    int busy;
    logic stable;
    wait_idle();
    pre       = {Quociente, Resto};
    Dividendo = N'(a);
    Divisor   = N'(b);
    Start     = 1'b1;
    sb.push_back(model(a, b));
    @(negedge Clk);
    Start     = 1'b0;
    Dividendo = N'($urandom);
    Divisor   = N'($urandom);
    k = 1;
    busy = 0;
    stable = 1'b1;
    while (!Finalizado && k < 40) begin
      if (Ocupado) busy++;
      if ({Quociente, Resto} !== pre) stable = 1'b0;
      @(negedge Clk);
      k++;
    end
    chk("latency", 32'(k), (b == 0) ? 32'd1 : 32'(N + 1));
    chk("ocupado_cycles", 32'(busy), (b == 0) ? 32'd0 : 32'(N));
    chk("ocupado_at_fim", 32'(Ocupado), 32'd0);
    if (b != 0) chk("outputs_hold_midcalc", 32'(stable), 32'd1);
  endtask

  initial begin
    int fin_seen;
    int last_fin;
    int cyc;
    int nfin;
    int a;
    int b;

    Rst = 1'b1;
    Start = 1'b0;
    Dividendo = '0;
    Divisor = '0;
    #12;
    chk("reset_outputs", {Quociente, Resto, Finalizado, Ocupado, ErroDivZero}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    run_op(200, 7);
    run_op(255, 1);
    run_op(5, 9);
    run_op(255, 255);
    run_op(0, 3);
    run_op(77, 0);
    run_op(10, 3);

    // Start re-pulsed during CALC and FIM must be ignored.
    wait_idle();
    Dividendo = 8'd100;
    Divisor = 8'd10;
    Start = 1'b1;
    sb.push_back(model(100, 10));
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Dividendo = 8'd9;
    Divisor = 8'd2;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cyc = 0;
    while (!Finalizado && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    chk("repulse_fin_timeout", 32'(cyc < 40), 32'd1);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    fin_seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Finalizado || Ocupado) fin_seen++;
    end
    chk("repulse_no_restart", 32'(fin_seen), 32'd0);
    chk("repulse_hold", {Quociente, Resto}, {16'd0, 8'd10, 8'd0});

    // Start held high: re-accepted every N+2 cycles.
    wait_idle();
    Dividendo = 8'd50;
    Divisor = 8'd6;
    Start = 1'b1;
    repeat (3) sb.push_back(model(50, 6));
    nfin = 0;
    cyc = 0;
    last_fin = 0;
    while (nfin < 3 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (Finalizado) begin
        if (nfin > 0) chk("held_period", 32'(cyc - last_fin), 32'(N + 2));
        last_fin = cyc;
        nfin++;
      end
    end
    Start = 1'b0;
    chk("held_count", 32'(nfin), 32'd3);

    // Asynchronous reset in the middle of CALC aborts the operation.
    wait_idle();
    Dividendo = 8'd200;
    Divisor = 8'd7;
    Start = 1'b1;
    sb.push_back(model(200, 7));
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("async_reset_outputs", {Quociente, Resto, Finalizado, Ocupado, ErroDivZero}, 32'd0);
    sb.delete();
    @(negedge Clk);
    Rst = 1'b0;
    fin_seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Finalizado || Ocupado) fin_seen++;
    end
    chk("abort_no_finalizado", 32'(fin_seen), 32'd0);
    run_op(200, 7);

    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(a, b);
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
